// File: rtl/segment_r_responder_pkg.sv
// Shared definitions for the segment operators.
// Contents:
//   SEG_DATA_W / SEG_ADDR_W : default segment word and address token widths
//   tok_flag_e              : encoding of the end-of-stream flag carried on tokens
package segment_r_responder_pkg;

    localparam int SEG_DATA_W = 64;
    localparam int SEG_ADDR_W = 32;

    typedef enum logic {
        TOK_DATA = 1'b0,
        TOK_EOS  = 1'b1
    } tok_flag_e;

endpackage

// File: rtl/segment_r_responder_if.sv
// Read-only segment interface: an address stream toward the responder and a
// data stream back to the requester. Each stream moves a token on a cycle
// where v=1 and b=0.
// Modports:
//   master : requester side (drives addr_*, data_b)
//   slave  : responder side (drives data_*, addr_b)
interface segment_r_responder_if
    import segment_r_responder_pkg::*;
#(
    parameter int DATA_W = SEG_DATA_W,
    parameter int ADDR_W = SEG_ADDR_W
);
    logic [ADDR_W-1:0] segment_r_addr_d;
    logic              segment_r_addr_e;
    logic              segment_r_addr_v;
    logic              segment_r_addr_b;
    logic [DATA_W-1:0] segment_r_data_d;
    logic              segment_r_data_e;
    logic              segment_r_data_v;
    logic              segment_r_data_b;

    modport master (
        output segment_r_addr_d, segment_r_addr_e, segment_r_addr_v, segment_r_data_b,
        input  segment_r_addr_b, segment_r_data_d, segment_r_data_e, segment_r_data_v
    );

    modport slave (
        input  segment_r_addr_d, segment_r_addr_e, segment_r_addr_v, segment_r_data_b,
        output segment_r_addr_b, segment_r_data_d, segment_r_data_e, segment_r_data_v
    );
endinterface

// File: rtl/segment_r_responder_outq.sv
// segment_r_outq: DEPTH-entry synchronous FIFO of {e,d} tokens with occupancy count.
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   push_i/push_e_i/d_i : write one token at the tail
//   pop_i               : remove the head token (caller guarantees non-empty)
//   head_e_o/head_d_o   : head token, all-zero while empty after reset
//   count_o             : number of tokens held
module segment_r_outq #(
    parameter  int W     = 64,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic             push_e_i,
    input  logic [W-1:0]     push_d_i,
    input  logic             pop_i,
    output logic             head_e_o,
    output logic [W-1:0]     head_d_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W:0]       slot_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: the few holding slots are reset so the head reads as zero out of
    // reset; the large segment array in the top level is deliberately not.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                slot_q[wr_ptr_q] <= {push_e_i, push_d_i};
                wr_ptr_q         <= bump(wr_ptr_q);
            end
            if (pop_i) rd_ptr_q <= bump(rd_ptr_q);
            count_q <= count_d;
        end
    end

    assign {head_e_o, head_d_o} = slot_q[rd_ptr_q];
    assign count_o              = count_q;
endmodule

// File: rtl/segment_r_responder.sv
// segment_r_responder: responder end of the read-only segment interface.
// Stage A accepts an address and reads the internal array; stage B holds the
// read word one cycle and pushes it to the output queue. One data token is
// returned per address token, in order.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   seg          : segment interface (slave side)
//   load_we/load_addr/load_data : array write port (read-before-write on collision)
//   range_err    : sticky, set when an out-of-range address is accepted
module segment_r_responder
    import segment_r_responder_pkg::*;
#(
    parameter int DATA_W     = SEG_DATA_W,
    parameter int ADDR_W     = SEG_ADDR_W,
    parameter int DEPTH_LOG2 = 8,
    parameter int Q_DEPTH    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    segment_r_responder_if.slave  seg,
    input  logic                  load_we,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [DATA_W-1:0]     load_data,
    output logic                  range_err
);
    localparam int WORDS = 1 << DEPTH_LOG2;
    localparam int CNT_W = $clog2(Q_DEPTH + 1);

    logic [DATA_W-1:0] array_q [WORDS];
    logic [DATA_W-1:0] rdata_q;

    logic inflight_q, inflight_d;
    logic eos_q, eos_d;
    logic zero_q, zero_d;
    logic range_err_q, range_err_d;
    logic ready_q;

    logic              tok_eos, addr_oor, accept, rd_en, pop, data_v, addr_b;
    logic [CNT_W-1:0]  q_count;
    logic [CNT_W:0]    occupancy;
    logic              head_e;
    logic [DATA_W-1:0] head_d, push_d;

    assign tok_eos  = (tok_flag_e'(seg.segment_r_addr_e) == TOK_EOS);
    assign addr_oor = |seg.segment_r_addr_d[ADDR_W-1:DEPTH_LOG2];

    assign data_v = (q_count != '0);
    assign pop    = data_v && !seg.segment_r_data_b;

    // Credit check: queued tokens plus the stage-B token may not exceed the
    // queue. A pop this cycle frees its slot before the new token can reach
    // the queue, which is what sustains one token per cycle at Q_DEPTH=2.
    assign occupancy = {1'b0, q_count} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
    assign addr_b    = !ready_q || (occupancy >= (CNT_W + 1)'(Q_DEPTH));

    assign accept = seg.segment_r_addr_v && !addr_b;
    // EOS tokens and out-of-range addresses never touch the array.
    assign rd_en  = accept && !tok_eos && !addr_oor;

    // NOTE: non-blocking writes and reads here make a same-address load and
    // read return the old word.
    always_ff @(posedge clock) begin
        if (load_we) array_q[load_addr] <= load_data;
        if (rd_en)   rdata_q <= array_q[seg.segment_r_addr_d[DEPTH_LOG2-1:0]];
    end

    always_comb begin
        inflight_d  = accept;
        eos_d       = accept && tok_eos;
        zero_d      = accept && (tok_eos || addr_oor);
        range_err_d = range_err_q || (accept && !tok_eos && addr_oor);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight_q  <= 1'b0;
            eos_q       <= 1'b0;
            zero_q      <= 1'b0;
            range_err_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            inflight_q  <= inflight_d;
            eos_q       <= eos_d;
            zero_q      <= zero_d;
            range_err_q <= range_err_d;
            ready_q     <= 1'b1;
        end
    end

    assign push_d = zero_q ? '0 : rdata_q;

    segment_r_outq #(
        .W     (DATA_W),
        .DEPTH (Q_DEPTH)
    ) u_outq (
        .clock    (clock),
        .reset    (reset),
        .push_i   (inflight_q),
        .push_e_i (eos_q),
        .push_d_i (push_d),
        .pop_i    (pop),
        .head_e_o (head_e),
        .head_d_o (head_d),
        .count_o  (q_count)
    );

    assign seg.segment_r_addr_b = addr_b;
    assign seg.segment_r_data_v = data_v;
    assign seg.segment_r_data_d = head_d;
    assign seg.segment_r_data_e = head_e;
    assign range_err            = range_err_q;
endmodule
